// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM-stage, data-memory response and register-file write signals of the writeback stage.
interface writeback_stage_if;
  logic        MEM_valid;
  logic        MEM_RegWrite;
  logic        MEM_MemToReg;
  logic        MEM_Link;
  logic [2:0]  MEM_funct3;
  logic [4:0]  MEM_Rd;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_pc_plus4;
  logic        DM_rvalid;
  logic [31:0] DM_rdata;
  logic [4:0]  WB_in_Rd;
  logic [31:0] WB_Mux_Mux_out;
  logic        WB_RegWrite;
  logic        WB_stall;
  logic        WB_load_err;
  modport master (
    output MEM_valid, MEM_RegWrite, MEM_MemToReg, MEM_Link, MEM_funct3, MEM_Rd,
           MEM_alu_result, MEM_pc_plus4, DM_rvalid, DM_rdata,
    input  WB_in_Rd, WB_Mux_Mux_out, WB_RegWrite, WB_stall, WB_load_err
  );
  modport slave (
    input  MEM_valid, MEM_RegWrite, MEM_MemToReg, MEM_Link, MEM_funct3, MEM_Rd,
           MEM_alu_result, MEM_pc_plus4, DM_rvalid, DM_rdata,
    output WB_in_Rd, WB_Mux_Mux_out, WB_RegWrite, WB_stall, WB_load_err
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load-response wait with timeout, load extraction and register-file write port.
// Define WB_SUBWORD_LOAD_EN for LB/LH/LBU/LHU support; without it only LW is a legal load.
module writeback_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic CLK,
  input logic RSTn,
  input logic EN,
  input logic START,
  writeback_stage_if.slave wb
);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [4:0] rd_q, rd_nx, ld_rd, wr_rd;
  logic [2:0] f3_q, f3_nx, ld_f3;
  logic [1:0] off_q, off_nx, ld_off;
  logic [31:0] ld_data, wr_data;
  logic ld_bad, wr_en, err_nx;
  // A load that does not write rd is tracked as rd=x0 so the handshake still runs without a strobe.
  assign ld_rd = state == IDLE ? (wb.MEM_RegWrite ? wb.MEM_Rd : 5'd0) : rd_q;
  assign ld_f3 = state == IDLE ? wb.MEM_funct3 : f3_q;
  assign ld_off = state == IDLE ? wb.MEM_alu_result[1:0] : off_q;
`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0] lb;
  logic [15:0] lh;
  assign lb = wb.DM_rdata[{ld_off, 3'b000} +: 8];
  assign lh = ld_off[1] ? wb.DM_rdata[31:16] : wb.DM_rdata[15:0];
  assign ld_data = ld_f3[1:0] == 2'b00 ? {{24{~ld_f3[2] & lb[7]}}, lb}
                 : ld_f3[1:0] == 2'b01 ? {{16{~ld_f3[2] & lh[15]}}, lh}
                 : wb.DM_rdata;
  assign ld_bad = (ld_f3[1] & (ld_f3[0] | ld_f3[2]))
                | ((ld_f3[1:0] == 2'b01) & ld_off[0])
                | ((ld_f3 == 3'b010) & (ld_off != 2'b00));
`else
  assign ld_data = wb.DM_rdata;
  assign ld_bad = (ld_f3 != 3'b010) || (ld_off != 2'b00);
`endif
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    rd_nx = rd_q;
    f3_nx = f3_q;
    off_nx = off_q;
    wr_en = 1'b0;
    wr_rd = 5'd0;
    wr_data = 32'd0;
    err_nx = wb.WB_load_err;
    if (state == IDLE) begin
      if (wb.MEM_valid && !wb.MEM_MemToReg) begin
        wr_en = wb.MEM_RegWrite && (wb.MEM_Rd != 5'd0);
        wr_rd = wb.MEM_Rd;
        wr_data = wb.MEM_Link ? wb.MEM_pc_plus4 : wb.MEM_alu_result;
      end else if (wb.MEM_valid && wb.DM_rvalid) begin
        wr_en = (ld_rd != 5'd0) && !ld_bad;
        wr_rd = ld_rd;
        wr_data = ld_data;
        err_nx = wb.WB_load_err | ld_bad;
      end else if (wb.MEM_valid) begin
        state_nx = LOAD_WAIT;
        cnt_nx = 8'd0;
        rd_nx = ld_rd;
        f3_nx = wb.MEM_funct3;
        off_nx = wb.MEM_alu_result[1:0];
      end
    end else if (wb.DM_rvalid) begin
      wr_en = (ld_rd != 5'd0) && !ld_bad;
      wr_rd = ld_rd;
      wr_data = ld_data;
      err_nx = wb.WB_load_err | ld_bad;
      state_nx = IDLE;
    end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
      err_nx = 1'b1;
      state_nx = IDLE;
    end else begin
      cnt_nx = cnt + 8'd1;
    end
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      cnt <= 8'd0;
      rd_q <= 5'd0;
      f3_q <= 3'd0;
      off_q <= 2'd0;
      wb.WB_RegWrite <= 1'b0;
      wb.WB_in_Rd <= 5'd0;
      wb.WB_Mux_Mux_out <= 32'd0;
      wb.WB_load_err <= 1'b0;
    end else if (EN && START) begin
      state <= state_nx;
      cnt <= cnt_nx;
      rd_q <= rd_nx;
      f3_q <= f3_nx;
      off_q <= off_nx;
      wb.WB_RegWrite <= wr_en;
      wb.WB_in_Rd <= wr_en ? wr_rd : 5'd0;
      wb.WB_Mux_Mux_out <= wr_en ? wr_data : 32'd0;
      wb.WB_load_err <= err_nx;
    end
  end
  assign wb.WB_stall = state == LOAD_WAIT;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage (default TIMEOUT_CYCLES=16).
module tb_writeback_stage;
  localparam int T = 16;
`ifdef WB_SUBWORD_LOAD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RSTn, EN, START;
  int tests = 0;
  int fails = 0;
  writeback_stage_if wb ();
  writeback_stage #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .EN(EN),
    .START(START),
    .wb(wb.slave)
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic clear_in();
    wb.MEM_valid = 0;
    wb.MEM_RegWrite = 0;
    wb.MEM_MemToReg = 0;
    wb.MEM_Link = 0;
    wb.MEM_funct3 = 0;
    wb.MEM_Rd = 0;
    wb.MEM_alu_result = 0;
    wb.MEM_pc_plus4 = 0;
    wb.DM_rvalid = 0;
    wb.DM_rdata = 0;
  endtask
  task automatic do_reset();
    RSTn = 0;
    EN = 1;
    START = 1;
    clear_in();
    step();
    step();
    RSTn = 1;
    step();
  endtask
  // Presents one instruction for a single clock edge; returns #1 after that edge.
  task automatic issue(input logic rw, mtr, link, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, pc4);
    wb.MEM_valid = 1;
    wb.MEM_RegWrite = rw;
    wb.MEM_MemToReg = mtr;
    wb.MEM_Link = link;
    wb.MEM_funct3 = f3;
    wb.MEM_Rd = rd;
    wb.MEM_alu_result = alu;
    wb.MEM_pc_plus4 = pc4;
    step();
    wb.MEM_valid = 0;
  endtask
  task automatic test_reset();
    RSTn = 0;
    EN = 1;
    START = 1;
    clear_in();
    step();
    tests++;
    if ({wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_RegWrite, wb.WB_stall, wb.WB_load_err} !== 40'd0) begin
      fails++;
      $display("FAIL reset_outputs got rd=%0d data=%h we=%b stall=%b err=%b expected all 0",
               wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_RegWrite, wb.WB_stall, wb.WB_load_err);
    end
    RSTn = 1;
    step();
  endtask
  task automatic test_alu();
    do_reset();
    issue(1, 0, 0, 3'd0, 5'd5, 32'h0000_1234, 32'h0);
    tests++;
    if ({wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      fails++;
      $display("FAIL alu_write got we=%b rd=%0d data=%h expected we=1 rd=5 data=00001234",
               wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out);
    end
    step();
    tests++;
    if ({wb.WB_RegWrite, wb.WB_in_Rd} !== 6'd0) begin
      fails++;
      $display("FAIL alu_strobe_end got we=%b rd=%0d expected we=0 rd=0", wb.WB_RegWrite, wb.WB_in_Rd);
    end
    issue(1, 0, 0, 3'd0, 5'd0, 32'h0000_5555, 32'h0);
    tests++;
    if ({wb.WB_RegWrite, wb.WB_in_Rd} !== 6'd0) begin
      fails++;
      $display("FAIL x0_no_write got we=%b rd=%0d expected we=0 rd=0", wb.WB_RegWrite, wb.WB_in_Rd);
    end
    START = 0;
    issue(1, 0, 0, 3'd0, 5'd6, 32'h0000_6666, 32'h0);
    tests++;
    if (wb.WB_RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL start_low_no_write got we=%b expected 0", wb.WB_RegWrite);
    end
    START = 1;
  endtask
  task automatic test_jal();
    do_reset();
    issue(1, 0, 1, 3'd0, 5'd1, 32'hDEAD_BEEF, 32'h0000_0104);
    tests++;
    if ({wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out} !== {1'b1, 5'd1, 32'h0000_0104}) begin
      fails++;
      $display("FAIL jal_link got we=%b rd=%0d data=%h expected we=1 rd=1 data=00000104",
               wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    issue(1, 0, 0, 3'd0, 5'd2, 32'h22, 32'h0);
    tests++;
    if ({wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out} !== {1'b1, 5'd2, 32'h22}) begin
      fails++;
      $display("FAIL b2b_first got we=%b rd=%0d data=%h expected we=1 rd=2 data=00000022",
               wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out);
    end
    issue(1, 0, 0, 3'd0, 5'd3, 32'h33, 32'h0);
    tests++;
    if ({wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out} !== {1'b1, 5'd3, 32'h33}) begin
      fails++;
      $display("FAIL b2b_second got we=%b rd=%0d data=%h expected we=1 rd=3 data=00000033",
               wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out);
    end
  endtask
  task automatic test_lb_wait();
    do_reset();
    issue(1, 1, 0, 3'b000, 5'd7, 32'h0000_1002, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (wb.WB_stall !== 1'b1 || wb.WB_RegWrite !== 1'b0) begin
        fails++;
        $display("FAIL lb_stall_%0d got stall=%b we=%b expected stall=1 we=0", i, wb.WB_stall, wb.WB_RegWrite);
      end
      if (i == 2) begin
        wb.DM_rvalid = 1;
        wb.DM_rdata = 32'h1280_5634;
      end
      step();
    end
    wb.DM_rvalid = 0;
    tests++;
    if ({wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_stall, wb.WB_load_err} !==
        (SUB ? {1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0} : {1'b0, 5'd0, 32'h0, 1'b0, 1'b1})) begin
      fails++;
      $display("FAIL lb_complete got we=%b rd=%0d data=%h stall=%b err=%b (subword=%0d)",
               wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_stall, wb.WB_load_err, SUB);
    end
  endtask
  task automatic test_load_extract();
    logic [2:0] f3 [9];
    logic [1:0] off [9];
    logic [31:0] rdata [9];
    logic [31:0] exp_d [9];
    bit ok [9];
    bit sub_only [9];
    bit we;
    logic [31:0] d;
    f3 = '{3'b010, 3'b010, 3'b101, 3'b001, 3'b001, 3'b100, 3'b000, 3'b011, 3'b110};
    off = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    rdata = '{32'hCAFE_F00D, 32'hCAFE_F00D, 32'hBEEF_0000, 32'hBEEF_0000, 32'h8001_0000,
              32'h0000_F100, 32'h0000_007F, 32'h1111_1111, 32'h2222_2222};
    exp_d = '{32'hCAFE_F00D, 32'h0, 32'h0000_BEEF, 32'h0, 32'hFFFF_8001, 32'h0000_00F1,
              32'h0000_007F, 32'h0, 32'h0};
    ok = '{1, 0, 1, 0, 1, 1, 1, 0, 0};
    sub_only = '{0, 0, 1, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      do_reset();
      wb.DM_rvalid = 1;
      wb.DM_rdata = rdata[i];
      issue(1, 1, 0, f3[i], 5'd4, {30'h100, off[i]}, 32'h0);
      wb.DM_rvalid = 0;
      we = ok[i] && (SUB || !sub_only[i]);
      d = we ? exp_d[i] : 32'h0;
      tests++;
      if ({wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_load_err, wb.WB_stall} !==
          {we, we ? 5'd4 : 5'd0, d, ~we, 1'b0}) begin
        fails++;
        $display("FAIL load_%0d f3=%b off=%0d got we=%b rd=%0d data=%h err=%b stall=%b expected we=%b data=%h err=%b",
                 i, f3[i], off[i], wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_load_err,
                 wb.WB_stall, we, d, ~we);
      end
    end
  endtask
  task automatic test_timeout();
    int n;
    bit saw_we;
    do_reset();
    issue(1, 1, 0, 3'b010, 5'd6, 32'h200, 32'h0);
    n = 0;
    saw_we = 0;
    while (wb.WB_stall === 1'b1 && n < 40) begin
      n++;
      step();
      saw_we |= wb.WB_RegWrite;
    end
    tests++;
    if (n != T) begin
      fails++;
      $display("FAIL timeout_stall_len got %0d cycles expected %0d", n, T);
    end
    tests++;
    if (wb.WB_load_err !== 1'b1 || saw_we) begin
      fails++;
      $display("FAIL timeout_err got err=%b saw_write=%0d expected err=1 saw_write=0", wb.WB_load_err, saw_we);
    end
    do_reset();
    issue(1, 1, 0, 3'b010, 5'd6, 32'h200, 32'h0);
    for (int i = 1; i < T; i++) step();
    tests++;
    if (wb.WB_stall !== 1'b1) begin
      fails++;
      $display("FAIL late_rvalid_still_waiting got stall=%b expected 1", wb.WB_stall);
    end
    wb.DM_rvalid = 1;
    wb.DM_rdata = 32'h1122_3344;
    step();
    wb.DM_rvalid = 0;
    tests++;
    if ({wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_load_err, wb.WB_stall} !==
        {1'b1, 5'd6, 32'h1122_3344, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL late_rvalid_wins got we=%b rd=%0d data=%h err=%b stall=%b expected we=1 rd=6 data=11223344 err=0 stall=0",
               wb.WB_RegWrite, wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_load_err, wb.WB_stall);
    end
  endtask
  task automatic test_reset_abort();
    do_reset();
    issue(1, 1, 0, 3'b010, 5'd8, 32'h300, 32'h0);
    step();
    tests++;
    if (wb.WB_stall !== 1'b1) begin
      fails++;
      $display("FAIL abort_waiting got stall=%b expected 1", wb.WB_stall);
    end
    RSTn = 0;
    #1;
    tests++;
    if ({wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_RegWrite, wb.WB_stall, wb.WB_load_err} !== 40'd0) begin
      fails++;
      $display("FAIL abort_async got rd=%0d data=%h we=%b stall=%b err=%b expected all 0",
               wb.WB_in_Rd, wb.WB_Mux_Mux_out, wb.WB_RegWrite, wb.WB_stall, wb.WB_load_err);
    end
    wb.DM_rvalid = 1;
    wb.DM_rdata = 32'hABCD_0123;
    step();
    RSTn = 1;
    step();
    wb.DM_rvalid = 0;
    tests++;
    if ({wb.WB_RegWrite, wb.WB_stall} !== 2'b00) begin
      fails++;
      $display("FAIL abort_no_write got we=%b stall=%b expected we=0 stall=0", wb.WB_RegWrite, wb.WB_stall);
    end
  endtask
  task automatic test_enable_hold();
    int n;
    bit saw_we;
    do_reset();
    issue(1, 1, 0, 3'b010, 5'd10, 32'h400, 32'h0);
    step();
    step();
    EN = 0;
    wb.DM_rvalid = 1;
    wb.DM_rdata = 32'h5A5A_5A5A;
    saw_we = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      saw_we |= wb.WB_RegWrite;
    end
    tests++;
    if (wb.WB_stall !== 1'b1 || saw_we) begin
      fails++;
      $display("FAIL en_low_hold got stall=%b saw_write=%0d expected stall=1 saw_write=0", wb.WB_stall, saw_we);
    end
    wb.DM_rvalid = 0;
    EN = 1;
    n = 0;
    while (wb.WB_stall === 1'b1 && n < 40) begin
      n++;
      step();
      saw_we |= wb.WB_RegWrite;
    end
    tests++;
    if (n != T - 2 || saw_we || wb.WB_load_err !== 1'b1) begin
      fails++;
      $display("FAIL en_counter_held got remaining=%0d saw_write=%0d err=%b expected remaining=%0d saw_write=0 err=1",
               n, saw_we, wb.WB_load_err, T - 2);
    end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_jal();
    test_back_to_back();
    test_lb_wait();
    test_load_extract();
    test_timeout();
    test_reset_abort();
    test_enable_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
